// File: rtl/pulse_train_gen.sv
// pulse_train_gen: emits a train of count_in pulses. Each pulse is
// LOW_CYCLES low followed by HIGH_CYCLES high. A one-cycle done strobe
// follows the train. The train can be cancelled with abort. sent counts
// the rising edges of the current or last train.
module pulse_train_gen #(
  parameter int unsigned WIDTH       = 4,
  parameter int unsigned HIGH_CYCLES = 2,
  parameter int unsigned LOW_CYCLES  = 2,
  parameter int unsigned TW          = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] count_in,
  input  logic             abort,
  output logic             ready,
  output logic             busy,
  output logic             pulse,
  output logic             done,
  output logic [WIDTH-1:0] sent
);

  typedef enum logic [1:0] {
    IDLE,
    LOW,
    HIGH,
    DONE
  } state_t;

  // Timer counts down to zero, so each phase loads its length minus one.
  localparam logic [TW-1:0] LOW_LOAD  = TW'(LOW_CYCLES - 1);
  localparam logic [TW-1:0] HIGH_LOAD = TW'(HIGH_CYCLES - 1);

  state_t           state;
  logic [WIDTH-1:0] target;
  logic [TW-1:0]    timer;

  // Main FSM; pulse, done and sent are registered alongside the state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      pulse  <= 1'b0;
      done   <= 1'b0;
      sent   <= '0;
      target <= '0;
      timer  <= '0;
    end else begin
      case (state)
        IDLE: begin
          pulse <= 1'b0;
          done  <= 1'b0;
          if (start) begin
            target <= count_in;
            sent   <= '0;
            timer  <= LOW_LOAD;
            if (count_in == '0) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              state <= LOW;
            end
          end
        end
        LOW: begin
          if (abort) begin
            state <= IDLE;
            pulse <= 1'b0;
          end else if (timer == '0) begin
            state <= HIGH;
            timer <= HIGH_LOAD;
            pulse <= 1'b1;
            // Bumped on the same edge as pulse rises; never passes target.
            if (sent != target) begin
              sent <= sent + WIDTH'(1);
            end
          end else begin
            timer <= timer - TW'(1);
          end
        end
        HIGH: begin
          if (abort) begin
            state <= IDLE;
            pulse <= 1'b0;
          end else if (timer == '0) begin
            pulse <= 1'b0;
            if (sent == target) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              state <= LOW;
              timer <= LOW_LOAD;
            end
          end else begin
            timer <= timer - TW'(1);
          end
        end
        DONE: begin
          state <= IDLE;
          done  <= 1'b0;
          pulse <= 1'b0;
        end
        default: begin
          state <= IDLE;
          pulse <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

  // Status flags decoded directly from the state register.
  always_comb begin
    ready = (state == IDLE);
    busy  = (state == LOW) || (state == HIGH);
  end

endmodule

// File: tb/tb_pulse_train_gen.sv
// tb_pulse_train_gen: table-driven and randomized check of pulse_train_gen
// against a cycle-indexed arithmetic reference model.
module tb_pulse_train_gen;

  localparam int W = 4;
  localparam int L = 2;
  localparam int H = 2;
  localparam int P = L + H;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] count_in;
  logic         abort;
  logic         ready;
  logic         busy;
  logic         pulse;
  logic         done;
  logic [W-1:0] sent;

  int n_cmp = 0;
  int n_err = 0;

  // Independent rising-edge counter observing the pulse output.
  logic pulse_q = 1'b0;
  int   edge_cnt = 0;

  pulse_train_gen #(
    .WIDTH      (W),
    .HIGH_CYCLES(H),
    .LOW_CYCLES (L),
    .TW         (8)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .count_in(count_in),
    .abort   (abort),
    .ready   (ready),
    .busy    (busy),
    .pulse   (pulse),
    .done    (done),
    .sent    (sent)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    pulse_q <= pulse;
    if (pulse && !pulse_q) edge_cnt <= edge_cnt + 1;
  end

  typedef struct {
    int n;
    int abort_at;
    int restart_at;
    int restart_n;
    int exp_edges;
    int exp_sent;
    int exp_dones;
    int exp_done_cyc;
  } vec_t;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Rising edges seen by the end of cycle c of a train (cycle 1 follows acceptance).
  function automatic int sent_at(input int c);
    return (c - 1) / P + ((((c - 1) % P) >= L) ? 1 : 0);
  endfunction

  // Expected outputs during cycle c of a train of n pulses, aborted during cycle ab (0 = never).
  task automatic model(input int n, input int ab, input int c,
                       output int e_ready, output int e_busy, output int e_pulse,
                       output int e_done, output int e_sent);
    int tot;
    tot = n * P;
    e_ready = 0; e_busy = 0; e_pulse = 0; e_done = 0; e_sent = 0;
    if (n > 0 && ab != 0 && ab <= tot && c > ab) begin
      e_ready = 1;
      e_sent  = sent_at(ab);
    end else if (c <= tot) begin
      e_busy  = 1;
      e_pulse = (((c - 1) % P) >= L) ? 1 : 0;
      e_sent  = sent_at(c);
    end else if (c == tot + 1) begin
      e_done = 1;
      e_sent = n;
    end else begin
      e_ready = 1;
      e_sent  = n;
    end
  endtask

  // Issues one train from IDLE and checks every cycle against the model.
  task automatic run_train(input int n, input int ab, input int rs, input int rsn,
                           output int edges, output int dones, output int done_cyc,
                           output int last_sent);
    int er, eb, ep, ed, es, prev;
    count_in = W'(n);
    start    = 1'b1;
    tick();
    start    = 1'b0;
    count_in = W'($urandom_range(0, 15));
    edges = 0; dones = 0; done_cyc = 0; prev = 0;
    for (int c = 1; c <= n * P + 4; c++) begin
      model(n, ab, c, er, eb, ep, ed, es);
      chk($sformatf("n%0d c%0d ready", n, c), int'(ready), er);
      chk($sformatf("n%0d c%0d busy", n, c), int'(busy), eb);
      chk($sformatf("n%0d c%0d pulse", n, c), int'(pulse), ep);
      chk($sformatf("n%0d c%0d done", n, c), int'(done), ed);
      chk($sformatf("n%0d c%0d sent", n, c), int'(sent), es);
      if (pulse && prev == 0) edges++;
      prev = int'(pulse);
      if (done) begin
        dones++;
        done_cyc = c;
      end
      abort = (c == ab);
      if (c == rs) begin
        start    = 1'b1;
        count_in = W'(rsn);
      end else begin
        start = 1'b0;
      end
      tick();
    end
    abort     = 1'b0;
    start     = 1'b0;
    last_sent = int'(sent);
  endtask

  vec_t vecs[8];

  initial begin
    int edges, dones, dcyc, lsent, e0, n, ab, rs;

    vecs[0] = '{n: 3,  abort_at: 0, restart_at: 0, restart_n: 0, exp_edges: 3,  exp_sent: 3,  exp_dones: 1, exp_done_cyc: 13};
    vecs[1] = '{n: 0,  abort_at: 0, restart_at: 0, restart_n: 0, exp_edges: 0,  exp_sent: 0,  exp_dones: 1, exp_done_cyc: 1};
    vecs[2] = '{n: 15, abort_at: 0, restart_at: 0, restart_n: 0, exp_edges: 15, exp_sent: 15, exp_dones: 1, exp_done_cyc: 61};
    vecs[3] = '{n: 2,  abort_at: 0, restart_at: 4, restart_n: 5, exp_edges: 2,  exp_sent: 2,  exp_dones: 1, exp_done_cyc: 9};
    vecs[4] = '{n: 4,  abort_at: 7, restart_at: 0, restart_n: 0, exp_edges: 2,  exp_sent: 2,  exp_dones: 0, exp_done_cyc: 0};
    vecs[5] = '{n: 6,  abort_at: 0, restart_at: 0, restart_n: 0, exp_edges: 6,  exp_sent: 6,  exp_dones: 1, exp_done_cyc: 25};
    vecs[6] = '{n: 1,  abort_at: 5, restart_at: 0, restart_n: 0, exp_edges: 1,  exp_sent: 1,  exp_dones: 1, exp_done_cyc: 5};
    vecs[7] = '{n: 2,  abort_at: 1, restart_at: 0, restart_n: 0, exp_edges: 0,  exp_sent: 0,  exp_dones: 0, exp_done_cyc: 0};

    // Reset dominates start and abort.
    rst = 1'b1; start = 1'b1; abort = 1'b1; count_in = W'(1);
    tick();
    tick();
    chk("rst ready", int'(ready), 1);
    chk("rst busy", int'(busy), 0);
    chk("rst pulse", int'(pulse), 0);
    chk("rst done", int'(done), 0);
    chk("rst sent", int'(sent), 0);

    // First edge with rst low accepts; start beats abort in IDLE.
    rst = 1'b0;
    tick();
    chk("first start busy", int'(busy), 1);
    chk("first start ready", int'(ready), 0);
    abort = 1'b0; start = 1'b0;
    for (int i = 0; i < 8; i++) tick();
    chk("first train idle", int'(ready), 1);

    // Table vectors.
    foreach (vecs[i]) begin
      e0 = edge_cnt;
      run_train(vecs[i].n, vecs[i].abort_at, vecs[i].restart_at, vecs[i].restart_n,
                edges, dones, dcyc, lsent);
      chk($sformatf("vec%0d edges", i), edges, vecs[i].exp_edges);
      chk($sformatf("vec%0d sent", i), lsent, vecs[i].exp_sent);
      chk($sformatf("vec%0d dones", i), dones, vecs[i].exp_dones);
      chk($sformatf("vec%0d done_cyc", i), dcyc, vecs[i].exp_done_cyc);
      chk($sformatf("vec%0d edge counter delta", i), edge_cnt - e0, vecs[i].exp_edges);
    end

    // Reset mid-train: pulse drops, no done strobe.
    count_in = W'(3); start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    chk("midrst pulse high before", int'(pulse), 1);
    rst = 1'b1;
    tick();
    chk("midrst pulse", int'(pulse), 0);
    chk("midrst done", int'(done), 0);
    chk("midrst ready", int'(ready), 1);
    chk("midrst sent", int'(sent), 0);
    rst = 1'b0;
    tick();
    chk("midrst done after", int'(done), 0);
    chk("midrst still idle", int'(ready), 1);

    // Randomized trains.
    for (int k = 0; k < 30; k++) begin
      n  = $urandom_range(0, 15);
      ab = 0;
      rs = 0;
      if ($urandom_range(0, 2) == 0) ab = $urandom_range(1, n * P + 2);
      else rs = $urandom_range(1, n * P + 1);
      e0 = edge_cnt;
      run_train(n, ab, rs, $urandom_range(0, 15), edges, dones, dcyc, lsent);
      chk($sformatf("rand%0d edge counter", k), edge_cnt - e0, edges);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
